consumidor_destinos: RTL and testbench
======================================

Name: consumidor_destinos

Overview:
- Downstream consumer of the transaction-layer core's two destination FIFOs (D0, D1).
- Drives pop_D0/pop_D1 with round-robin arbitration and captures data_out0/data_out1 one cycle after each pop.
- Checks each word's destination bit against the FIFO it came from.
- Presents words on a single valid/ready output stream, with per-destination counters and a sticky misroute error.

Parameters:
- DATA_W, 6, word width; bit DATA_W-1 = VC, bit DATA_W-2 = destination (0 = D0, 1 = D1), low bits = payload.
- CNT_W, 8, width of the per-destination word counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- active_in  input  1  core's active_out; pops are issued only while high.
- empty_D0  input  1  D0 FIFO empty.
- empty_D1  input  1  D1 FIFO empty.
- data_out0  input  DATA_W  D0 FIFO read data, valid the cycle after pop_D0.
- data_out1  input  DATA_W  D1 FIFO read data, valid the cycle after pop_D1.
- out_ready  input  1  sink accepts out_data this cycle.
- clr_err  input  1  synchronous clear of misroute_err and return from ERROR.
- pop_D0  output  1  pop request to D0 FIFO.
- pop_D1  output  1  pop request to D1 FIFO.
- out_valid  output  1  out_data holds a word.
- out_data  output  DATA_W  captured word.
- out_dest  output  1  FIFO the word came from (0 = D0, 1 = D1).
- cnt_D0  output  CNT_W  words delivered from D0, saturating.
- cnt_D1  output  CNT_W  words delivered from D1, saturating.
- misroute_err  output  1  sticky; set when the destination bit does not equal the source FIFO.
- busy  output  1  high when the state is RUN or a word is in flight.

Behaviour:
- Reset (reset_L = 0, asynchronous):
  - All outputs go to 0.
  - Skid buffer empties, round-robin pointer goes to D0, state goes to WAIT.
- States:
  - WAIT: pops are disabled. Go to RUN when active_in = 1.
  - RUN: arbitrate and pop. Go to WAIT when active_in = 0; words already in flight still complete. Go to ERROR on a misroute.
  - ERROR: pops are disabled. Go to WAIT on clr_err = 1.
- Pop rule in RUN, per cycle:
  - Eligible FIFO: not empty, and storage credit available.
  - Credit is available when (entries held + pops in flight) < 2.
  - At most one pop per cycle.
  - Both FIFOs eligible: pop the one the pointer indicates, then toggle the pointer.
  - One FIFO eligible: pop it; the pointer moves to the other FIFO.
  - pop_D0 and pop_D1 are never high in the same cycle.
- Capture:
  - A pop issued in cycle N is registered at the end of cycle N+1 from data_out0/data_out1.
  - The source id is registered with it.
  - Capture is unconditional once a pop is issued; credit accounting guarantees space.
- Output stream:
  - 2-entry FIFO (skid buffer); out_valid = not empty.
  - A transfer happens when out_valid = 1 and out_ready = 1.
  - out_data and out_dest hold stable while out_valid = 1 and out_ready = 0.
  - With back-to-back pops and out_ready = 1, throughput is one word per cycle.
  - Capture and transfer in the same cycle leave the occupancy unchanged.
- Counters:
  - Increment on transfer, according to out_dest.
  - Saturate at 2^CNT_W - 1.
  - Reset only by reset_L.
- Misroute check:
  - Applied at capture: data[DATA_W-2] must equal the source id.
  - On mismatch: misroute_err sets the next cycle and the state goes to ERROR.
  - The offending word is still delivered.
- clr_err:
  - Clears misroute_err.
  - Takes priority over a new misroute on the same cycle only in ERROR.
- active_in falling mid-operation:
  - No new pops are issued.
  - The in-flight capture completes and the buffer drains normally.
- Empty flags:
  - Sampled in the pop cycle; the FIFO guarantees data on the following cycle.
  - Popping an empty FIFO never occurs.

Test Plan:
- Reset, active_in = 1, D0 holds 0x0B, 0x0A and D1 empty, out_ready = 1:
  - pop_D0 high in cycles 1-2.
  - out_data 0x0B then 0x0A, out_dest = 0.
  - cnt_D0 = 2, misroute_err = 0.
- Both FIFOs non-empty, D0 {0x03, 0x09}, D1 {0x1D, 0x1B}:
  - Pops alternate D0, D1, D0, D1.
  - out_data sequence 0x03, 0x1D, 0x09, 0x1B.
  - cnt_D0 = 2, cnt_D1 = 2.
- out_ready = 0 with 4 words available:
  - Exactly 2 pops occur, then pops stop.
  - out_data is held.
  - Raising out_ready resumes at one word per cycle with no loss or duplication.
- D0 returns 0x1B (destination bit = 1):
  - Word is delivered with out_dest = 0.
  - misroute_err = 1, no further pops.
  - clr_err clears the error; with active_in high the block resumes via WAIT to RUN.
- active_in dropped the cycle after a pop:
  - That word is still delivered.
  - No further pop_D0/pop_D1 occurs.
  - busy falls after drain.
- reset_L asserted asynchronously mid-stream:
  - out_valid, pops, counters and misroute_err go to 0 immediately.
  - Resumes from WAIT after release.

Source files
------------

// File: rtl/consumidor_destinos.sv
// ============================================================================
// Module      : consumidor_destinos
// Description : Round-robin consumer of the D0/D1 destination FIFOs feeding a
//               single valid/ready stream with counters and misroute check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module consumidor_destinos #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active_in,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_dest,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              misroute_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_inflight;
  logic              r_inflight_src;
  logic              r_rr;
  logic [DATA_W:0]   r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;
  logic              r_err;

  logic              w_xfer;
  logic [1:0]        w_held;
  logic [1:0]        w_used;
  logic              w_pop_en;
  logic              w_el0;
  logic              w_el1;
  logic              w_pop0;
  logic              w_pop1;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_mis;
  logic              w_err_nxt;

  assign w_xfer   = (r_count != 2'd0) && out_ready;
  // A word leaving this cycle frees its slot for a pop issued this cycle.
  assign w_held   = r_count - {1'b0, w_xfer};
  assign w_used   = w_held + {1'b0, r_inflight};
  assign w_pop_en = (r_state == ST_RUN) && active_in && (w_used < 2'd2);
  assign w_el0    = w_pop_en && !empty_D0;
  assign w_el1    = w_pop_en && !empty_D1;
  assign w_pop0   = w_el0 && (!w_el1 || !r_rr);
  assign w_pop1   = w_el1 && (!w_el0 || r_rr);

  assign w_cap_data = r_inflight_src ? data_out1 : data_out0;
  assign w_mis      = r_inflight && (w_cap_data[DATA_W-2] != r_inflight_src);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_WAIT:  if (w_mis) w_state_nxt = ST_ERROR;
                else if (active_in) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_mis) w_state_nxt = ST_ERROR;
                else if (!active_in) w_state_nxt = ST_WAIT;
      ST_ERROR: if (clr_err) w_state_nxt = ST_WAIT;
      default:  w_state_nxt = ST_WAIT;
    endcase
    if ((r_state == ST_ERROR) && clr_err) w_err_nxt = 1'b0;
    else if (w_mis)                       w_err_nxt = 1'b1;
    else if (clr_err)                     w_err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state        <= ST_WAIT;
      r_err          <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_src <= 1'b0;
      r_rr           <= 1'b0;
      r_mem[0]       <= '0;
      r_mem[1]       <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_cnt0         <= '0;
      r_cnt1         <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_err          <= w_err_nxt;
      r_inflight     <= w_pop0 || w_pop1;
      r_inflight_src <= w_pop1;
      if (w_pop0 || w_pop1) r_rr <= w_pop0;
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= {r_inflight_src, w_cap_data};
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_xfer) r_rd_ptr <= !r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
      if (w_xfer && !out_dest && (r_cnt0 != c_CNT_MAX)) r_cnt0 <= r_cnt0 + c_CNT_ONE;
      if (w_xfer &&  out_dest && (r_cnt1 != c_CNT_MAX)) r_cnt1 <= r_cnt1 + c_CNT_ONE;
    end
  end

  assign pop_D0       = w_pop0;
  assign pop_D1       = w_pop1;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_mem[r_rd_ptr][DATA_W-1:0];
  assign out_dest     = r_mem[r_rd_ptr][DATA_W];
  assign cnt_D0       = r_cnt0;
  assign cnt_D1       = r_cnt1;
  assign misroute_err = r_err;
  assign busy         = (r_state == ST_RUN) || r_inflight || (r_count != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_consumidor_destinos.sv
// ============================================================================
// Module      : tb_consumidor_destinos
// Description : Table-driven bench for consumidor_destinos with FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_consumidor_destinos;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              active_in = 1'b0;
  logic              empty_D0 = 1'b1;
  logic              empty_D1 = 1'b1;
  logic [DATA_W-1:0] data_out0 = '0;
  logic [DATA_W-1:0] data_out1 = '0;
  logic              out_ready = 1'b1;
  logic              clr_err = 1'b0;
  logic              pop_D0;
  logic              pop_D1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_dest;
  logic [CNT_W-1:0]  cnt_D0;
  logic [CNT_W-1:0]  cnt_D1;
  logic              misroute_err;
  logic              busy;

  consumidor_destinos #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .active_in(active_in),
    .empty_D0(empty_D0), .empty_D1(empty_D1),
    .data_out0(data_out0), .data_out1(data_out1),
    .out_ready(out_ready), .clr_err(clr_err),
    .pop_D0(pop_D0), .pop_D1(pop_D1),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
    .misroute_err(misroute_err), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W:0]   got[$];
  int                got_cyc[$];
  int                pop_cyc[$];
  int                cyc = 0;
  int                base = 0;
  int                both_pops = 0;
  int                bad_pops = 0;
  int                nvec = 0;
  int                nerr = 0;
  int                m_cnt0 = 0;
  int                m_cnt1 = 0;

  // FIFO models: read data appears the cycle after the pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_D0 && q0.size() > 0) data_out0 <= q0.pop_front();
    if (pop_D1 && q1.size() > 0) data_out1 <= q1.pop_front();
    empty_D0 <= (q0.size() == 0);
    empty_D1 <= (q1.size() == 0);
  end

  always @(negedge clk) begin
    if (reset_L) begin
      if (pop_D0 && pop_D1) both_pops++;
      if ((pop_D0 && empty_D0) || (pop_D1 && empty_D1)) bad_pops++;
      if (pop_D0 || pop_D1) pop_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        got.push_back({out_dest, out_data});
        got_cyc.push_back(cyc);
      end
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DATA_W:0] got_at(int k);
    if (got.size() > k) return got[k];
    return '1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [DATA_W-1:0] d);
    q0.push_back(d);
    empty_D0 = 1'b0;
  endtask

  task automatic push1(input logic [DATA_W-1:0] d);
    q1.push_back(d);
    empty_D1 = 1'b0;
  endtask

  task automatic clear_logs();
    got.delete();
    got_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_words", (got.size() >= n) ? n : got.size(), n);
  endtask

  task automatic add_cnt(input logic dest);
    if (dest) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
    else      m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
  endtask

  // Ends just after release: cycle 1 is the first cycle in which state can be RUN
  task automatic do_reset();
    #3 reset_L = 1'b0;
    step();
    q0.delete();
    q1.delete();
    empty_D0 = 1'b1;
    empty_D1 = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    clear_logs();
    reset_L = 1'b1;
    base = cyc;
  endtask

  typedef struct {
    bit                rst_first;
    int                n0;
    logic [DATA_W-1:0] d0[4];
    int                n1;
    logic [DATA_W-1:0] d1[4];
    int                nexp;
    logic [DATA_W:0]   exp_w[4];
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1'b1, 2, '{6'h0B, 6'h0A, 6'h00, 6'h00}, 0, '{6'h00, 6'h00, 6'h00, 6'h00},
               2, '{7'h0B, 7'h0A, 7'h00, 7'h00}};
    tbl[1] = '{1'b1, 2, '{6'h03, 6'h09, 6'h00, 6'h00}, 2, '{6'h1D, 6'h1B, 6'h00, 6'h00},
               4, '{7'h03, 7'h5D, 7'h09, 7'h5B}};
    tbl[2] = '{1'b0, 0, '{6'h00, 6'h00, 6'h00, 6'h00}, 2, '{6'h15, 6'h3F, 6'h00, 6'h00},
               2, '{7'h55, 7'h7F, 7'h00, 7'h00}};
    tbl[3] = '{1'b0, 3, '{6'h21, 6'h0F, 6'h00, 6'h00}, 1, '{6'h10, 6'h00, 6'h00, 6'h00},
               4, '{7'h21, 7'h50, 7'h0F, 7'h00}};

    active_in = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pops", {pop_D0, pop_D1}, 0);
    chk("rst_cnt", {cnt_D0, cnt_D1}, 0);
    chk("rst_err", misroute_err, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].rst_first) do_reset();
      clear_logs();
      for (int k = 0; k < tbl[i].n0; k++) push0(tbl[i].d0[k]);
      for (int k = 0; k < tbl[i].n1; k++) push1(tbl[i].d1[k]);
      wait_got(tbl[i].nexp, 40);
      for (int k = 0; k < tbl[i].nexp; k++) begin
        chk($sformatf("vec%0d_word%0d", i, k), got_at(k), tbl[i].exp_w[k]);
        add_cnt(tbl[i].exp_w[k][DATA_W]);
      end
      if (i == 0) begin
        chk("first_pop_count", pop_cyc.size(), 2);
        chk("first_pop_cycles", (pop_cyc.size() == 2) ? {pop_cyc[0] - base, pop_cyc[1] - base} : 64'd0, {32'd1, 32'd2});
      end
      step();
      step();
      chk($sformatf("vec%0d_cnt0", i), cnt_D0, m_cnt0);
      chk($sformatf("vec%0d_cnt1", i), cnt_D1, m_cnt1);
      chk($sformatf("vec%0d_err", i), misroute_err, 0);
    end

    // Backpressure: two pops fill the buffer, then resume at full rate
    clear_logs();
    out_ready = 1'b0;
    push0(6'h01); push0(6'h02); push1(6'h11); push1(6'h12);
    repeat (8) step();
    chk("bp_pops", pop_cyc.size(), 2);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", {out_dest, out_data}, 7'h51);
    repeat (3) step();
    chk("bp_hold", {out_dest, out_data}, 7'h51);
    out_ready = 1'b1;
    wait_got(4, 20);
    chk("bp_w0", got_at(0), 7'h51);
    chk("bp_w1", got_at(1), 7'h01);
    chk("bp_w2", got_at(2), 7'h52);
    chk("bp_w3", got_at(3), 7'h02);
    chk("bp_rate", (got_cyc.size() == 4) ? got_cyc[3] - got_cyc[0] : 0, 3);
    m_cnt0 += 2;
    m_cnt1 += 2;

    // Misroute: word with destination bit 1 returned by D0
    clear_logs();
    push0(6'h1B);
    wait_got(1, 20);
    chk("mis_word", got_at(0), 7'h1B);
    chk("mis_err", misroute_err, 1);
    push0(6'h02);
    clear_logs();
    repeat (5) step();
    chk("mis_no_pop", pop_cyc.size(), 0);
    chk("mis_err_sticky", misroute_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", misroute_err, 0);
    wait_got(1, 20);
    chk("resume_word", got_at(0), 7'h02);
    m_cnt0 += 2;
    step();
    chk("mis_cnt0", cnt_D0, m_cnt0);

    // active_in dropped the cycle after a pop
    step();
    clear_logs();
    push0(6'h04); push0(6'h05); push0(6'h06);
    step();
    active_in = 1'b0;
    chk("drop_busy_hi", busy, 1);
    repeat (6) step();
    chk("drop_pops", pop_cyc.size(), 1);
    chk("drop_word", got_at(0), 7'h04);
    chk("drop_busy_lo", busy, 0);

    // Asynchronous reset mid-stream
    active_in = 1'b1;
    repeat (3) step();
    chk("pre_rst_valid", out_valid, 1);
    #3 reset_L = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pops", {pop_D0, pop_D1}, 0);
    chk("arst_cnt", {cnt_D0, cnt_D1}, 0);
    chk("arst_err", misroute_err, 0);
    step();
    q0.delete();
    q1.delete();
    empty_D0 = 1'b1;
    empty_D1 = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    clear_logs();
    reset_L = 1'b1;
    base = cyc;
    push1(6'h1C);
    wait_got(1, 20);
    chk("arst_resume_word", got_at(0), 7'h5C);
    chk("arst_resume_cyc", (pop_cyc.size() > 0) ? pop_cyc[0] - base : 0, 1);
    add_cnt(1'b1);

    // Counter saturation on D1
    clear_logs();
    for (int k = 0; k < 260; k++) begin
      push1(6'h10);
      add_cnt(1'b1);
    end
    wait_got(260, 700);
    step();
    step();
    chk("sat_cnt1", cnt_D1, m_cnt1);
    chk("sat_cnt0", cnt_D0, 0);

    chk("never_both_pops", both_pops, 0);
    chk("never_pop_empty", bad_pops, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
